// File: rtl/bomb_pool.sv
// bomb_pool: per-player pool of fused bombs with timed flame crosses,
// chain detonation between own bombs and a flame hit probe.
module bomb_pool #(
    parameter int NUM_BOMBS    = 4,
    parameter int FUSE_FRAMES  = 120,
    parameter int FLAME_FRAMES = 30,
    parameter int TILE_LOG2    = 4,
    parameter int RANGE        = 2,
    parameter int COORD_W      = 10
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic                           make,
    input  logic                           detonate,
    input  logic [COORD_W-1:0]             userX,
    input  logic [COORD_W-1:0]             userY,
    input  logic [COORD_W-1:0]             probeX,
    input  logic [COORD_W-1:0]             probeY,
    output logic [NUM_BOMBS-1:0]           bomb_active,
    output logic [NUM_BOMBS-1:0]           bomb_flame,
    output logic [NUM_BOMBS*COORD_W-1:0]   bombX,
    output logic [NUM_BOMBS*COORD_W-1:0]   bombY,
    output logic [COORD_W-1:0]             flameXS,
    output logic [COORD_W-1:0]             flameYS,
    output logic [$clog2(NUM_BOMBS+1)-1:0] live_count,
    output logic                           full,
    output logic                           hit
);

    localparam int TW = COORD_W - TILE_LOG2;
    localparam int SW = COORD_W + 1;
    localparam int CW = $clog2(NUM_BOMBS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FUSE,
        S_FLAME
    } state_e;

    state_e         state_q [NUM_BOMBS];
    state_e         state_d [NUM_BOMBS];
    logic [7:0]     timer_q [NUM_BOMBS];
    logic [7:0]     timer_d [NUM_BOMBS];
    logic [TW-1:0]  tx_q    [NUM_BOMBS];
    logic [TW-1:0]  tx_d    [NUM_BOMBS];
    logic [TW-1:0]  ty_q    [NUM_BOMBS];
    logic [TW-1:0]  ty_d    [NUM_BOMBS];
    logic           make_q;
    logic           make_d;

    logic [TW-1:0]  ux;
    logic [TW-1:0]  uy;
    logic [TW-1:0]  px;
    logic [TW-1:0]  py;
    logic           req;
    logic           dup;
    logic           taken;
    logic [NUM_BOMBS-1:0] alloc_oh;
    logic [NUM_BOMBS-1:0] chain;
    logic           unused_low;

    assign ux = userX[COORD_W-1:TILE_LOG2];
    assign uy = userY[COORD_W-1:TILE_LOG2];
    assign px = probeX[COORD_W-1:TILE_LOG2];
    assign py = probeY[COORD_W-1:TILE_LOG2];
    assign unused_low = ^{userX[TILE_LOG2-1:0], userY[TILE_LOG2-1:0],
                          probeX[TILE_LOG2-1:0], probeY[TILE_LOG2-1:0]};

    assign flameXS = COORD_W'(RANGE << TILE_LOG2);
    assign flameYS = COORD_W'(RANGE << TILE_LOG2);

    // Tile (ax,ay) lies on the arms of a cross centred on (cx,cy).
    function automatic logic in_cross(input logic [TW-1:0] ax,
                                      input logic [TW-1:0] ay,
                                      input logic [TW-1:0] cx,
                                      input logic [TW-1:0] cy);
        logic [SW-1:0] dx;
        logic [SW-1:0] dy;
        logic [SW-1:0] adx;
        logic [SW-1:0] ady;
        dx  = SW'(ax) - SW'(cx);
        dy  = SW'(ay) - SW'(cy);
        adx = dx[SW-1] ? -dx : dx;
        ady = dy[SW-1] ? -dy : dy;
        return ((dy == '0) && (adx <= SW'(RANGE))) ||
               ((dx == '0) && (ady <= SW'(RANGE)));
    endfunction

    // Slot allocation, fuse/flame timing, chain and detonate next-state.
    always_comb begin
        make_d   = make;
        req      = make & ~make_q;
        dup      = 1'b0;
        taken    = 1'b0;
        alloc_oh = '0;
        chain    = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            tx_d[i]    = tx_q[i];
            ty_d[i]    = ty_q[i];
            if (state_q[i] != S_IDLE && tx_q[i] == ux && ty_q[i] == uy)
                dup = 1'b1;
            if (!taken && state_q[i] == S_IDLE) begin
                alloc_oh[i] = 1'b1;
                taken       = 1'b1;
            end
            for (int j = 0; j < NUM_BOMBS; j++) begin
                if (state_q[j] == S_FLAME &&
                    in_cross(tx_q[i], ty_q[i], tx_q[j], ty_q[j]))
                    chain[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_BOMBS; i++) begin
            case (state_q[i])
                S_IDLE: begin
                    if (req && !dup && alloc_oh[i]) begin
                        state_d[i] = S_FUSE;
                        timer_d[i] = 8'(FUSE_FRAMES - 1);
                        tx_d[i]    = ux;
                        ty_d[i]    = uy;
                    end
                end
                S_FUSE: begin
                    if (timer_q[i] == 8'd0 || chain[i] || detonate) begin
                        state_d[i] = S_FLAME;
                        timer_d[i] = 8'(FLAME_FRAMES - 1);
                    end else begin
                        timer_d[i] = timer_q[i] - 8'd1;
                    end
                end
                S_FLAME: begin
                    if (timer_q[i] == 8'd0) begin
                        state_d[i] = S_IDLE;
                    end else begin
                        timer_d[i] = timer_q[i] - 8'd1;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Slot state registers with asynchronous clear.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            make_q <= 1'b0;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state_q[i] <= S_IDLE;
                timer_q[i] <= '0;
                tx_q[i]    <= '0;
                ty_q[i]    <= '0;
            end
        end else begin
            make_q <= make_d;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                tx_q[i]    <= tx_d[i];
                ty_q[i]    <= ty_d[i];
            end
        end
    end

    // Flattened slot outputs, occupancy and probe hit from registered state.
    always_comb begin
        live_count = '0;
        hit        = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            bomb_active[i] = (state_q[i] != S_IDLE);
            bomb_flame[i]  = (state_q[i] == S_FLAME);
            bombX[i*COORD_W +: COORD_W] = {tx_q[i], {TILE_LOG2{1'b0}}};
            bombY[i*COORD_W +: COORD_W] = {ty_q[i], {TILE_LOG2{1'b0}}};
            if (bomb_active[i])
                live_count = live_count + CW'(1);
            if (bomb_flame[i] && in_cross(px, py, tx_q[i], ty_q[i]))
                hit = 1'b1;
        end
        full = &bomb_active;
    end

endmodule

// File: tb/tb_bomb_pool.sv
// tb_bomb_pool: directed checks of drop, fuse/flame timing, occupancy,
// chain detonation, probe hit and asynchronous reset.
module tb_bomb_pool;

    logic        clk = 1'b0;
    logic        rst;
    logic        make;
    logic        detonate;
    logic [9:0]  ux;
    logic [9:0]  uy;
    logic [9:0]  prx;
    logic [9:0]  pry;
    logic [3:0]  active;
    logic [3:0]  flame;
    logic [39:0] bx;
    logic [39:0] by;
    logic [9:0]  fxs;
    logic [9:0]  fys;
    logic [2:0]  live;
    logic        full;
    logic        hit;

    int errors = 0;
    int checks = 0;

    bomb_pool #(
        .NUM_BOMBS(4),
        .FUSE_FRAMES(8),
        .FLAME_FRAMES(4),
        .TILE_LOG2(4),
        .RANGE(2),
        .COORD_W(10)
    ) dut (
        .frame_clk(clk),
        .Reset(rst),
        .make(make),
        .detonate(detonate),
        .userX(ux),
        .userY(uy),
        .probeX(prx),
        .probeY(pry),
        .bomb_active(active),
        .bomb_flame(flame),
        .bombX(bx),
        .bombY(by),
        .flameXS(fxs),
        .flameYS(fys),
        .live_count(live),
        .full(full),
        .hit(hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input logic [9:0] x, input logic [9:0] y);
        ux   = x;
        uy   = y;
        make = 1'b1;
        tick();
        make = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({active, flame, live, full, hit} !== 13'd0) begin
            errors++;
            $display("FAIL reset_flags got %b req 0",
                     {active, flame, live, full, hit});
        end
        checks++;
        if ({bx, by} !== 80'd0) begin
            errors++;
            $display("FAIL reset_pos got %h req 0", {bx, by});
        end
        checks++;
        if (fxs !== 10'd32 || fys !== 10'd32) begin
            errors++;
            $display("FAIL flame_size got %0d/%0d req 32/32", fxs, fys);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lifecycle();
        do_reset();
        drop(10'd37, 10'd70);
        checks++;
        if (active !== 4'b0001 || live !== 3'd1) begin
            errors++;
            $display("FAIL drop_slot0 got act=%b live=%0d req 0001/1",
                     active, live);
        end
        checks++;
        if (bx[9:0] !== 10'd32 || by[9:0] !== 10'd64) begin
            errors++;
            $display("FAIL drop_snap got %0d,%0d req 32,64",
                     bx[9:0], by[9:0]);
        end
        repeat (7) tick();
        checks++;
        if (flame !== 4'b0000) begin
            errors++;
            $display("FAIL fuse_end got flame=%b req 0000", flame);
        end
        tick();
        checks++;
        if (flame !== 4'b0001) begin
            errors++;
            $display("FAIL flame_rise got flame=%b req 0001", flame);
        end
        repeat (3) tick();
        checks++;
        if (flame !== 4'b0001) begin
            errors++;
            $display("FAIL flame_hold got flame=%b req 0001", flame);
        end
        tick();
        checks++;
        if (active !== 4'b0000 || flame !== 4'b0000) begin
            errors++;
            $display("FAIL flame_end got act=%b flame=%b req 0000",
                     active, flame);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drop(10'(k * 16 + 3), 10'd5);
            tick();
        end
        checks++;
        if (full !== 1'b1 || live !== 3'd4 || active !== 4'b1111) begin
            errors++;
            $display("FAIL fill_four got full=%b live=%0d act=%b req 1/4/1111",
                     full, live, active);
        end
        checks++;
        if (bx[39:30] !== 10'd48) begin
            errors++;
            $display("FAIL fill_slot3x got %0d req 48", bx[39:30]);
        end
        drop(10'd64, 10'd5);
        checks++;
        if (live !== 3'd4 || flame !== 4'b0001) begin
            errors++;
            $display("FAIL fill_fifth got live=%0d flame=%b req 4/0001",
                     live, flame);
        end
    endtask

    task automatic test_same_tile();
        do_reset();
        drop(10'd37, 10'd70);
        tick();
        drop(10'd40, 10'd75);
        checks++;
        if (live !== 3'd1 || active !== 4'b0001) begin
            errors++;
            $display("FAIL dup_tile got live=%0d act=%b req 1/0001",
                     live, active);
        end
        tick();
        drop(10'd60, 10'd70);
        checks++;
        if (live !== 3'd2 || bx[19:10] !== 10'd48) begin
            errors++;
            $display("FAIL next_tile got live=%0d x=%0d req 2/48",
                     live, bx[19:10]);
        end
        tick();
        ux   = 10'd200;
        make = 1'b1;
        repeat (3) tick();
        make = 1'b0;
        checks++;
        if (live !== 3'd3) begin
            errors++;
            $display("FAIL make_held got live=%0d req 3", live);
        end
    endtask

    task automatic test_chain();
        do_reset();
        drop(10'd32, 10'd32);
        repeat (4) tick();
        drop(10'd64, 10'd32);
        tick();
        drop(10'd80, 10'd48);
        checks++;
        if (flame !== 4'b0000 || active !== 4'b0111) begin
            errors++;
            $display("FAIL chain_setup got flame=%b act=%b req 0000/0111",
                     flame, active);
        end
        tick();
        checks++;
        if (flame !== 4'b0001) begin
            errors++;
            $display("FAIL chain_first got flame=%b req 0001", flame);
        end
        tick();
        checks++;
        if (flame !== 4'b0011) begin
            errors++;
            $display("FAIL chain_hop got flame=%b req 0011", flame);
        end
        tick();
        checks++;
        if (flame !== 4'b0011) begin
            errors++;
            $display("FAIL chain_third got flame=%b req 0011", flame);
        end
        repeat (4) tick();
        checks++;
        if (flame !== 4'b0000 || active !== 4'b0100) begin
            errors++;
            $display("FAIL chain_after got flame=%b act=%b req 0000/0100",
                     flame, active);
        end
        tick();
        checks++;
        if (flame !== 4'b0100) begin
            errors++;
            $display("FAIL chain_natural got flame=%b req 0100", flame);
        end
    endtask

    task automatic test_hit();
        do_reset();
        drop(10'd80, 10'd80);
        prx = 10'd85;
        pry = 10'd85;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_fuse got %b req 0", hit);
        end
        repeat (8) tick();
        prx = 10'd117;
        pry = 10'd89;
        #1;
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_7_5 got %b req 1", hit);
        end
        prx = 10'd80;
        pry = 10'd48;
        #1;
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_5_3 got %b req 1", hit);
        end
        prx = 10'd128;
        pry = 10'd80;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_8_5 got %b req 0", hit);
        end
        prx = 10'd96;
        pry = 10'd96;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_6_6 got %b req 0", hit);
        end
        prx = 10'd0;
        pry = 10'd0;
    endtask

    task automatic test_detonate();
        do_reset();
        drop(10'd16, 10'd16);
        tick();
        detonate = 1'b1;
        tick();
        detonate = 1'b0;
        checks++;
        if (flame !== 4'b0001 || active !== 4'b0001) begin
            errors++;
            $display("FAIL detonate got flame=%b act=%b req 0001/0001",
                     flame, active);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drop(10'd0, 10'd0);
        tick();
        drop(10'd160, 10'd0);
        tick();
        drop(10'd0, 10'd160);
        repeat (4) tick();
        prx = 10'd5;
        pry = 10'd17;
        #1;
        checks++;
        if (flame !== 4'b0001 || live !== 3'd3 || hit !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got flame=%b live=%0d hit=%b req 0001/3/1",
                     flame, live, hit);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({active, flame, live, full, hit} !== 13'd0 || {bx, by} !== 80'd0) begin
            errors++;
            $display("FAIL mid_reset got %b pos=%h req 0",
                     {active, flame, live, full, hit}, {bx, by});
        end
        rst = 1'b0;
        tick();
        drop(10'd37, 10'd70);
        checks++;
        if (active !== 4'b0001 || bx[9:0] !== 10'd32) begin
            errors++;
            $display("FAIL mid_resume got act=%b x=%0d req 0001/32",
                     active, bx[9:0]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        make     = 1'b0;
        detonate = 1'b0;
        ux       = '0;
        uy       = '0;
        prx      = '0;
        pry      = '0;
        test_reset();
        test_lifecycle();
        test_fill();
        test_same_tile();
        test_chain();
        test_hit();
        test_detonate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
